pwm_audio_out: RTL



---
 rtl/pwm_audio_out_pkg.sv | 19 +
 rtl/pwm_audio_out_if.sv | 14 +
 rtl/pwm_audio_out_noise_shaper.sv | 52 +++++
 rtl/pwm_audio_out.sv | 90 +++++++++
 4 files changed

// File: rtl/pwm_audio_out_pkg.sv
// Shared definitions for the PWM audio output stage.
// Contents: sample width, midscale constant, legal PWM resolution limits and
// the signed-to-offset-binary conversion used when a sample is captured.
package pwm_audio_out_pkg;

    localparam int SAMPLE_W     = 16;
    localparam int PWM_BITS_MIN = 4;
    localparam int PWM_BITS_MAX = 12;

    typedef logic [SAMPLE_W-1:0] sample_t;

    localparam sample_t MIDSCALE = 16'h8000;

    // Flipping the sign bit maps -32768..32767 onto 0..65535 with silence at midscale.
    function automatic sample_t to_offset_binary(input logic signed [SAMPLE_W-1:0] sample);
        return sample_t'(sample) ^ MIDSCALE;
    endfunction

endpackage

// File: rtl/pwm_audio_out_if.sv
// Sample handshake from the channel mixer into the PWM output stage.
//   data       : signed two's-complement mixed sample
//   data_valid : one-cycle strobe, data is valid in that cycle
// master = mixer side (drives), slave = PWM stage (receives).
interface pwm_audio_out_if;
    import pwm_audio_out_pkg::*;

    sample_t data;
    logic    data_valid;

    modport master (output data, output data_valid);
    modport slave  (input  data, input  data_valid);

endinterface

// File: rtl/pwm_audio_out_noise_shaper.sv
// First-order error-feedback noise shaper.
// Adds the residue left over from the previous truncation to the new sample,
// then splits the 17-bit sum into a PWM duty (upper bits) and a new residue
// (dropped LSBs). A carry out of the sum saturates the duty to full scale and
// clears the residue so a loud sample can never wrap to a low duty.
// Ports:
//   clk_in, reset_in : clock, synchronous active-high reset
//   load_en          : update the residue register (PWM load cycle)
//   src              : offset-binary sample selected for this period
//   duty_next        : duty to register at the load cycle
module pwm_noise_shaper
    import pwm_audio_out_pkg::*;
#(
    parameter int PWM_BITS    = 8,
    parameter int NOISE_SHAPE = 1
) (
    input  logic                clk_in,
    input  logic                reset_in,
    input  logic                load_en,
    input  sample_t             src,
    output logic [PWM_BITS-1:0] duty_next
);

    localparam int ERR_W = SAMPLE_W - PWM_BITS;

    logic [ERR_W-1:0]  err;
    logic [ERR_W-1:0]  err_next;
    logic [SAMPLE_W:0] sum;

    always_comb begin
        sum       = {1'b0, src} + {{(PWM_BITS + 1){1'b0}}, err};
        duty_next = '1;
        err_next  = '0;
        if (!sum[SAMPLE_W]) begin
            duty_next = sum[SAMPLE_W-1 -: PWM_BITS];
            err_next  = sum[ERR_W-1:0];
        end
        // Plain truncation: the residue is discarded every period.
        if (NOISE_SHAPE == 0) begin
            err_next = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            err <= '0;
        end else if (load_en) begin
            err <= err_next;
        end
    end

endmodule

// File: rtl/pwm_audio_out.sv
// PWM audio output stage, fed by the tone generator's channel mixer.
// One signed sample arrives per frame on a valid strobe; it is buffered as
// pending and picked up at the last count of a PWM period, optionally noise
// shaped, and played as a duty cycle for the whole following period.
// Ports:
//   clk_in           : system clock
//   reset_in         : synchronous active-high reset
//   audio            : sample handshake (slave side)
//   pwm_out          : registered PWM bit for the external RC filter
//   overrun_out      : one-cycle pulse when an unconsumed pending sample is overwritten
//   period_start_out : one-cycle pulse aligned with counter value 0
module pwm_audio_out
    import pwm_audio_out_pkg::*;
#(
    parameter int PWM_BITS    = 8,
    parameter int NOISE_SHAPE = 1
) (
    input  logic              clk_in,
    input  logic              reset_in,
    pwm_audio_out_if.slave    audio,
    output logic              pwm_out,
    output logic              overrun_out,
    output logic              period_start_out
);

    if (PWM_BITS < PWM_BITS_MIN || PWM_BITS > PWM_BITS_MAX) begin : g_bad_pwm_bits
        $error("pwm_audio_out: PWM_BITS out of legal range");
    end

    localparam logic [PWM_BITS-1:0] CNT_LAST   = '1;
    localparam logic [PWM_BITS-1:0] DUTY_RESET = {1'b1, {(PWM_BITS - 1){1'b0}}};

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] duty_next;
    sample_t             pending;
    sample_t             held;
    sample_t             src;
    sample_t             sample_u;
    logic                pending_valid;
    logic                load;

    assign load     = (pwm_cnt == CNT_LAST);
    assign sample_u = to_offset_binary(audio.data);
    // Without a fresh sample the previous one is replayed rather than dropping to silence.
    assign src      = pending_valid ? pending : held;

    pwm_noise_shaper #(
        .PWM_BITS    (PWM_BITS),
        .NOISE_SHAPE (NOISE_SHAPE)
    ) u_shaper (
        .clk_in    (clk_in),
        .reset_in  (reset_in),
        .load_en   (load),
        .src       (src),
        .duty_next (duty_next)
    );

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            pwm_cnt          <= '0;
            pending          <= '0;
            pending_valid    <= 1'b0;
            held             <= MIDSCALE;
            duty             <= DUTY_RESET;
            pwm_out          <= 1'b0;
            overrun_out      <= 1'b0;
            period_start_out <= 1'b0;
        end else begin
            pwm_cnt          <= pwm_cnt + 1'b1;
            pwm_out          <= (pwm_cnt < duty);
            // The counter is at its last value exactly when it wraps to 0 next.
            period_start_out <= load;
            // A load in the same cycle consumes the old pending, so nothing is lost.
            overrun_out      <= audio.data_valid && pending_valid && !load;

            if (load) begin
                held          <= src;
                duty          <= duty_next;
                pending_valid <= 1'b0;
            end
            // Placed after the load so a simultaneous strobe stays pending.
            if (audio.data_valid) begin
                pending       <= sample_u;
                pending_valid <= 1'b1;
            end
        end
    end

endmodule
